// File: rtl/serial_sub16.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Operands are captured on start; d/bout/ovf are held in their own registers between operations.
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               borrow_q, borrow_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;

    logic               x, y, diff, borrow_nxt, last_bit;
    logic [WIDTH-1:0]   acc_nxt;

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode directly from registered state and result registers
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        d    = d_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

    // One full-subtractor bit slice per RUN cycle
    always_comb begin
        x          = sa_q[0];
        y          = sb_q[0];
        diff       = x ^ y ^ borrow_q;
        borrow_nxt = (~x & y) | (~(x ^ y) & borrow_q);
        acc_nxt    = {diff, acc_q[WIDTH-1:1]};
        last_bit   = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Datapath next-state
    always_comb begin
        // NOTE: every target gets a hold default first, so no path leaves a latch.
        cnt_d    = cnt_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                end
            end
            RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                borrow_d = borrow_nxt;
                acc_d    = acc_nxt;
                if (last_bit) begin
                    d_d    = acc_nxt;
                    bout_d = borrow_nxt;
                    ovf_d  = (a_msb_q != b_msb_q) && (acc_nxt[WIDTH-1] != a_msb_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16: directed corner cases, randomized operands,
// handshake timing and asynchronous abort, against an arithmetic reference model.
module tb_serial_sub16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic [W-1:0] d;
    logic         bout, ovf, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Results of the most recent do_op call
    int           r_busy_cycles;
    bit           r_ok;
    bit           r_held;
    bit           r_done_after;
    logic [W-1:0] r_d;
    logic         r_bout, r_ovf;

    serial_sub16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] ed, output logic eb, output logic eo);
        int ua, ub, dif, sa, sb, sr;
        ua  = int'(ma);
        ub  = int'(mb);
        dif = ua - ub - int'(mbin);
        ed  = dif[W-1:0];
        eb  = (ua < ub + int'(mbin));
        sa  = int'($signed(ma));
        sb  = int'($signed(mb));
        sr  = sa - sb - int'(mbin);
        eo  = (sr > 32767) || (sr < -32768);
    endtask

    // Pulse start, wait (bounded) for done, record what was observed
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        logic [W-1:0] d_before;
        @(negedge clk);
        d_before = d;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        r_busy_cycles = 0;
        r_ok = 1'b0;
        r_held = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                r_ok = 1'b1;
                break;
            end
            if (busy) begin
                r_busy_cycles++;
                if (d !== d_before) r_held = 1'b0;
            end
            @(negedge clk);
        end
        r_d = d; r_bout = bout; r_ovf = ovf;
        @(negedge clk);
        r_done_after = done;
        checks++;
        if (!r_ok) begin
            errors++;
            $display("FAIL op_timeout: done not seen within 40 cycles (a=%h b=%h bin=%0d)", ia, ib, ibin);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({d, bout, ovf, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_async: d=%h bout=%b ovf=%b busy=%b done=%b, required all 0", d, bout, ovf, busy, done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({d, bout, ovf, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_held: d=%h bout=%b ovf=%b busy=%b done=%b, required all 0", d, bout, ovf, busy, done);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [6] = '{16'h001F, 16'hC61F, 16'h0000, 16'h8000, 16'hFFFF, 16'h1234};
        logic [W-1:0] vb [6] = '{16'h000C, 16'h018C, 16'h0001, 16'h0001, 16'h0000, 16'h1234};
        logic         vc [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [W-1:0] ed;
        logic         eb, eo;
        for (int i = 0; i < 6; i++) begin
            model(va[i], vb[i], vc[i], ed, eb, eo);
            do_op(va[i], vb[i], vc[i]);
            checks++;
            if (r_d !== ed || r_bout !== eb || r_ovf !== eo) begin
                errors++;
                $display("FAIL vec%0d_result: d=%h bout=%b ovf=%b, required d=%h bout=%b ovf=%b", i, r_d, r_bout, r_ovf, ed, eb, eo);
            end
            checks++;
            if (r_busy_cycles != W) begin
                errors++;
                $display("FAIL vec%0d_busy_len: %0d cycles, required %0d", i, r_busy_cycles, W);
            end
            checks++;
            if (!r_held) begin
                errors++;
                $display("FAIL vec%0d_hold: d changed during RUN, required stable", i);
            end
            checks++;
            if (r_done_after !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_done_width: done=%b one cycle later, required 0", i, r_done_after);
            end
        end
    endtask

    task automatic test_input_change();
        int dones = 0;
        bit seen = 1'b0;
        @(negedge clk);
        a = 16'h0005; b = 16'h0003; bin = 1'b0; start = 1'b1;
        @(negedge clk);                       // RUN cycle 1
        start = 1'b0;
        @(negedge clk);                       // RUN cycle 2: ignored start
        a = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);            // RUN cycle 5
        a = 16'h1234; b = 16'h4321; bin = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (!seen) begin
                    seen = 1'b1;
                    checks++;
                    if (d !== 16'h0002 || bout !== 1'b0 || ovf !== 1'b0) begin
                        errors++;
                        $display("FAIL capture_result: d=%h bout=%b ovf=%b, required d=0002 bout=0 ovf=0", d, bout, ovf);
                    end
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL capture_done_count: %0d done pulses, required 1", dones);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL capture_no_restart: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, dones = 0;
        bit prev;
        logic [W-1:0] ed;
        logic eb, eo;
        bit ok = 1'b0;
        model(16'hA5A5, 16'h5A5B, 1'b0, ed, eb, eo);
        @(negedge clk);
        a = 16'hA5A5; b = 16'h5A5B; bin = 1'b0; start = 1'b1;
        prev = busy;
        for (int i = 0; i < 60 && t2 < 0; i++) begin
            @(negedge clk);
            if (busy && !prev) begin
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
            if (done) dones++;
            prev = busy;
        end
        start = 1'b0;
        checks++;
        if (t2 < 0 || (t2 - t1) != W + 2) begin
            errors++;
            $display("FAIL b2b_period: acceptance spacing %0d (t1=%0d t2=%0d), required %0d", t2 - t1, t1, t2, W + 2);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL b2b_done_between: %0d done pulses, required 1", dones);
        end
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok || d !== ed || bout !== eb || ovf !== eo) begin
            errors++;
            $display("FAIL b2b_result: done=%b d=%h bout=%b ovf=%b, required d=%h bout=%b ovf=%b", ok, d, bout, ovf, ed, eb, eo);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int dones = 0;
        logic [W-1:0] ed;
        logic eb, eo;
        do_op(16'h0000, 16'h0001, 1'b0);      // leaves d=FFFF, bout=1 so the clear is visible
        checks++;
        if (r_d !== 16'hFFFF || r_bout !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: d=%h bout=%b, required d=ffff bout=1", r_d, r_bout);
        end
        @(negedge clk);
        a = 16'h7777; b = 16'h1111; bin = 1'b0; start = 1'b1;
        @(negedge clk);                       // RUN cycle 1
        start = 1'b0;
        repeat (7) @(negedge clk);            // RUN cycle 8
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({d, bout, ovf, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_clear: d=%h bout=%b ovf=%b busy=%b done=%b, required all 0", d, bout, ovf, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0 || d !== '0) begin
            errors++;
            $display("FAIL abort_quiet: %0d busy/done cycles, d=%h, required 0 and 0000", dones, d);
        end
        model(16'h7777, 16'h1111, 1'b0, ed, eb, eo);
        do_op(16'h7777, 16'h1111, 1'b0);
        checks++;
        if (r_d !== ed || r_bout !== eb || r_ovf !== eo || r_busy_cycles != W) begin
            errors++;
            $display("FAIL abort_fresh: d=%h bout=%b ovf=%b busy=%0d, required d=%h bout=%b ovf=%b busy=%0d",
                     r_d, r_bout, r_ovf, r_busy_cycles, ed, eb, eo, W);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, ed;
        logic rc, eb, eo;
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            rc = 1'($urandom_range(0, 1));
            model(ra, rb, rc, ed, eb, eo);
            do_op(ra, rb, rc);
            checks++;
            if (r_d !== ed || r_bout !== eb || r_ovf !== eo || r_busy_cycles != W) begin
                errors++;
                $display("FAIL rand%0d: a=%h b=%h bin=%b got d=%h bout=%b ovf=%b busy=%0d, required d=%h bout=%b ovf=%b busy=%0d",
                         i, ra, rb, rc, r_d, r_bout, r_ovf, r_busy_cycles, ed, eb, eo, W);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_input_change();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
